// File: rtl/seg_pkg.sv
// Shared glyph codes, display modes and converter state encoding for the
// seven-segment scan driver and its BCD converter.
package seg_pkg;

    localparam logic [4:0] GLYPH_H     = 5'h10;
    localparam logic [4:0] GLYPH_I     = 5'h11;
    localparam logic [4:0] GLYPH_L     = 5'h12;
    localparam logic [4:0] GLYPH_P     = 5'h13;
    localparam logic [4:0] GLYPH_T     = 5'h14;
    localparam logic [4:0] GLYPH_Y     = 5'h15;
    localparam logic [4:0] GLYPH_BLANK = 5'h1F;

    localparam int unsigned SCORE_MAX = 9999;

    typedef enum logic [1:0] {
        MODE_SCORE = 2'd0,
        MODE_PLAY  = 2'd1,
        MODE_LOST  = 2'd2,
        MODE_HI    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_t;

    // Message text packed digit3..digit0, five bits per glyph.
    function automatic logic [4:0] msg_glyph(input mode_t mode, input logic [1:0] idx);
        logic [19:0] msg;
        case (mode)
            MODE_PLAY: msg = {GLYPH_P, GLYPH_L, 5'h0A, GLYPH_Y};
            MODE_LOST: msg = {GLYPH_L, 5'h00, 5'h05, GLYPH_T};
            MODE_HI:   msg = {GLYPH_H, GLYPH_I, GLYPH_BLANK, GLYPH_BLANK};
            default:   msg = {4{GLYPH_BLANK}};
        endcase
        return msg[idx*5 +: 5];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle.
// state      | meaning
// CONV_IDLE  | waiting for start, captures bin into the shift register
// CONV_SHIFT | W iterations of add-3-then-shift-left
// CONV_DONE  | bcd holds the result for one cycle, done asserted
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int W = 14
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic [15:0]  bcd
);

    localparam int CW = $clog2(W);

    conv_state_t     state;
    logic [15+W:0]   sreg;
    logic [CW-1:0]   iter_cnt;
    logic [15:0]     adj;

    always_comb begin
        adj = '0;
        for (int i = 0; i < 4; i++) begin
            adj[i*4 +: 4] = (sreg[W+i*4 +: 4] >= 4'd5) ? sreg[W+i*4 +: 4] + 4'd3
                                                       : sreg[W+i*4 +: 4];
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= CONV_IDLE;
            sreg     <= '0;
            iter_cnt <= '0;
        end else begin
            case (state)
                CONV_IDLE: begin
                    if (start) begin
                        sreg     <= {16'd0, bin};
                        iter_cnt <= CW'(W - 1);
                        state    <= CONV_SHIFT;
                    end
                end
                CONV_SHIFT: begin
                    sreg <= {adj[14:0], sreg[W-1:0], 1'b0};
                    if (iter_cnt == '0) begin
                        state <= CONV_DONE;
                    end else begin
                        iter_cnt <= iter_cnt - 1'b1;
                    end
                end
                CONV_DONE: state <= CONV_IDLE;
                default:   state <= CONV_IDLE;
            endcase
        end
    end

    assign busy = (state != CONV_IDLE);
    assign done = (state == CONV_DONE);
    assign bcd  = sreg[15+W:W];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit scan driver: saturates and converts the score to BCD, blanks
// leading zeros or overlays mode text, and multiplexes one digit per slot.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int SCORE_W     = 14
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic [SCORE_W-1:0] SCORE,
    input  logic [1:0]         MODE,
    input  logic               PAUSE,
    output logic [1:0]         SEG_SELECT_OUT,
    output logic [4:0]         BIN_OUT,
    output logic               DOT_OUT
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]      presc;
    logic               tick;
    logic [1:0]         digit;
    logic [SCORE_W-1:0] score_clamped;
    logic [SCORE_W-1:0] last_conv;
    logic [SCORE_W-1:0] pend_val;
    logic [15:0]        bcd_disp;
    logic [15:0]        conv_bcd;
    logic               conv_busy;
    logic               conv_done;
    logic               conv_start;
    logic [3:0]         nib;
    logic               blank;
    logic [4:0]         glyph_next;

    assign tick          = (presc == PW'(REFRESH_DIV - 1));
    assign score_clamped = (32'(SCORE) > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE;
    // Only start from IDLE, so changes during a conversion wait for the next pass.
    assign conv_start    = (score_clamped != last_conv) && !conv_busy;

    bin2bcd_seq #(.W(SCORE_W)) u_bin2bcd (
        .CLK    (CLK),
        .RESETN (RESETN),
        .start  (conv_start),
        .bin    (score_clamped),
        .busy   (conv_busy),
        .done   (conv_done),
        .bcd    (conv_bcd)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            presc     <= '0;
            digit     <= '0;
            pend_val  <= '0;
            last_conv <= '0;
            bcd_disp  <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) digit <= digit + 1'b1;
            if (conv_start) pend_val <= score_clamped;
            if (conv_done) begin
                bcd_disp  <= conv_bcd;
                last_conv <= pend_val;
            end
        end
    end

    always_comb begin
        nib   = bcd_disp[digit*4 +: 4];
        blank = 1'b0;
        case (digit)
            2'd3:    blank = (bcd_disp[15:12] == 4'd0);
            2'd2:    blank = (bcd_disp[15:8]  == 8'd0);
            2'd1:    blank = (bcd_disp[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
        if (mode_t'(MODE) == MODE_SCORE) begin
            glyph_next = blank ? GLYPH_BLANK : {1'b0, nib};
        end else begin
            glyph_next = msg_glyph(mode_t'(MODE), digit);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            SEG_SELECT_OUT <= '0;
            BIN_OUT        <= '0;
            DOT_OUT        <= 1'b0;
        end else begin
            SEG_SELECT_OUT <= digit;
            BIN_OUT        <= glyph_next;
            DOT_OUT        <= PAUSE && (digit == 2'd0);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV = 4; expected scan
// position and glyphs come from a cycle count since reset and a decimal model.
module tb_seg_scan_driver;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [13:0] SCORE = '0;
    logic [1:0]  MODE = '0;
    logic        PAUSE = 1'b0;
    logic [1:0]  SEG_SELECT_OUT;
    logic [4:0]  BIN_OUT;
    logic        DOT_OUT;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    seg_scan_driver #(.REFRESH_DIV(4), .SCORE_W(14)) dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .SCORE          (SCORE),
        .MODE           (MODE),
        .PAUSE          (PAUSE),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .BIN_OUT        (BIN_OUT),
        .DOT_OUT        (DOT_OUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Digit shown after the c-th edge since reset release.
    function automatic logic [1:0] exp_seg(input int c);
        return (c == 0) ? 2'd0 : 2'(((c - 1) / 4) % 4);
    endfunction

    function automatic logic [4:0] exp_glyph(input int mode, input int value, input int k);
        int v, p;
        case (mode)
            1: case (k) 0: return 5'h15; 1: return 5'h0A; 2: return 5'h12; default: return 5'h13; endcase
            2: case (k) 0: return 5'h14; 1: return 5'h05; 2: return 5'h00; default: return 5'h12; endcase
            3: case (k) 0: return 5'h1F; 1: return 5'h1F; 2: return 5'h11; default: return 5'h10; endcase
            default: begin
                v = (value > 9999) ? 9999 : value;
                p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
                if (k > 0 && v < p) return 5'h1F;
                return 5'((v / p) % 10);
            end
        endcase
    endfunction

    task automatic test_reset;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK) SCORE = 14'(i * 3001);
            @(posedge CLK); #1;
            n_checks++;
            if (SEG_SELECT_OUT !== 2'd0 || BIN_OUT !== 5'h00 || DOT_OUT !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold i=%0d: got seg=%0d bin=%h dot=%b, want 0/00/0",
                         i, SEG_SELECT_OUT, BIN_OUT, DOT_OUT);
            end
        end
        @(negedge CLK) SCORE = '0;
    endtask

    task automatic test_scan_rate;
        logic [1:0] es;
        logic [4:0] eg;
        @(negedge CLK) RESETN = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge CLK); #1;
            es = exp_seg(cyc);
            eg = exp_glyph(0, 0, es);
            n_checks++;
            if (SEG_SELECT_OUT !== es || BIN_OUT !== eg || DOT_OUT !== 1'b0) begin
                n_fail++;
                $display("FAIL scan_rate n=%0d: got seg=%0d bin=%h dot=%b, want seg=%0d bin=%h dot=0",
                         n, SEG_SELECT_OUT, BIN_OUT, DOT_OUT, es, eg);
            end
        end
    endtask

    task automatic test_score(input int v_old, input int v_new, input string name);
        logic [1:0] es;
        logic [4:0] eg;
        int ev;
        @(negedge CLK) SCORE = 14'(v_new);
        for (int n = 1; n <= 32; n++) begin
            @(posedge CLK); #1;
            ev = (n < 17) ? v_old : v_new;
            es = exp_seg(cyc);
            eg = exp_glyph(0, ev, es);
            n_checks++;
            if (SEG_SELECT_OUT !== es || BIN_OUT !== eg || DOT_OUT !== 1'b0) begin
                n_fail++;
                $display("FAIL %s n=%0d: got seg=%0d bin=%h dot=%b, want seg=%0d bin=%h dot=0",
                         name, n, SEG_SELECT_OUT, BIN_OUT, DOT_OUT, es, eg);
            end
        end
    endtask

    task automatic test_mid_change;
        logic [1:0] es;
        logic [4:0] eg;
        int ev;
        @(negedge CLK) SCORE = 14'd50;
        for (int n = 1; n <= 48; n++) begin
            @(posedge CLK); #1;
            ev = (n < 17) ? 9999 : (n < 33) ? 50 : 51;
            es = exp_seg(cyc);
            eg = exp_glyph(0, ev, es);
            n_checks++;
            if (SEG_SELECT_OUT !== es || BIN_OUT !== eg) begin
                n_fail++;
                $display("FAIL mid_change n=%0d: got seg=%0d bin=%h, want seg=%0d bin=%h",
                         n, SEG_SELECT_OUT, BIN_OUT, es, eg);
            end
            if (n == 3) @(negedge CLK) SCORE = 14'd51;
        end
    endtask

    task automatic test_messages;
        logic [1:0] es;
        logic [4:0] eg;
        for (int m = 1; m <= 3; m++) begin
            @(negedge CLK) MODE = 2'(m);
            for (int n = 1; n <= 16; n++) begin
                @(posedge CLK); #1;
                es = exp_seg(cyc);
                eg = exp_glyph(m, 51, es);
                n_checks++;
                if (SEG_SELECT_OUT !== es || BIN_OUT !== eg) begin
                    n_fail++;
                    $display("FAIL message mode=%0d n=%0d: got seg=%0d bin=%h, want seg=%0d bin=%h",
                             m, n, SEG_SELECT_OUT, BIN_OUT, es, eg);
                end
            end
        end
        @(negedge CLK) MODE = 2'd0;
    endtask

    task automatic test_dot;
        logic [1:0] es;
        logic       ed;
        @(negedge CLK) PAUSE = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            @(posedge CLK); #1;
            es = exp_seg(cyc);
            ed = PAUSE && (es == 2'd0);
            n_checks++;
            if (SEG_SELECT_OUT !== es || DOT_OUT !== ed) begin
                n_fail++;
                $display("FAIL dot n=%0d: got seg=%0d dot=%b, want seg=%0d dot=%b",
                         n, SEG_SELECT_OUT, DOT_OUT, es, ed);
            end
            if (n == 24) @(negedge CLK) PAUSE = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        logic [1:0] es;
        logic [4:0] eg;
        int ev;
        @(negedge CLK) SCORE = 14'd999;
        repeat (5) @(posedge CLK);
        #2 RESETN = 1'b0;
        #1;
        n_checks++;
        if (SEG_SELECT_OUT !== 2'd0 || BIN_OUT !== 5'h00 || DOT_OUT !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got seg=%0d bin=%h dot=%b, want 0/00/0",
                     SEG_SELECT_OUT, BIN_OUT, DOT_OUT);
        end
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (SEG_SELECT_OUT !== 2'd0 || BIN_OUT !== 5'h00 || DOT_OUT !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got seg=%0d bin=%h dot=%b, want 0/00/0",
                     SEG_SELECT_OUT, BIN_OUT, DOT_OUT);
        end
        @(negedge CLK) RESETN = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            @(posedge CLK); #1;
            ev = (n < 17) ? 0 : 999;
            es = exp_seg(cyc);
            eg = exp_glyph(0, ev, es);
            n_checks++;
            if (SEG_SELECT_OUT !== es || BIN_OUT !== eg || DOT_OUT !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_reconv n=%0d: got seg=%0d bin=%h dot=%b, want seg=%0d bin=%h dot=0",
                         n, SEG_SELECT_OUT, BIN_OUT, DOT_OUT, es, eg);
            end
        end
    endtask

    initial begin
        test_reset;
        test_scan_rate;
        test_score(0, 1234, "score_1234");
        test_score(1234, 7, "score_7");
        test_score(7, 405, "score_405");
        test_score(405, 1000, "score_1000");
        test_score(1000, 12000, "saturate_12000");
        test_score(12000, 16383, "saturate_16383");
        test_mid_change;
        test_messages;
        test_dot;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
